// File: rtl/periph_arbiter_if.sv
// Bus bundle between two requesting masters, the arbiter, and the single
// downstream peripheral slave. The arbiter connects through the "slave" modport.
interface periph_arbiter_if #(
   parameter int XLEN = 32
);
   logic            i_m0_req;
   logic            i_m0_wen;
   logic            i_m0_lock;
   logic [XLEN-1:0] i_m0_addr;
   logic [XLEN-1:0] i_m0_wrdata;
   logic            o_m0_gnt;
   logic            o_m0_rvalid;
   logic            o_m0_err;
   logic [XLEN-1:0] o_m0_rddata;

   logic            i_m1_req;
   logic            i_m1_wen;
   logic            i_m1_lock;
   logic [XLEN-1:0] i_m1_addr;
   logic [XLEN-1:0] i_m1_wrdata;
   logic            o_m1_gnt;
   logic            o_m1_rvalid;
   logic            o_m1_err;
   logic [XLEN-1:0] o_m1_rddata;

   logic            o_s_wen;
   logic            o_s_ren;
   logic [XLEN-1:0] o_s_addr;
   logic [XLEN-1:0] o_s_wrdata;
   logic [XLEN-1:0] i_s_rddata;

   modport slave (
      input  i_m0_req, i_m0_wen, i_m0_lock, i_m0_addr, i_m0_wrdata,
      output o_m0_gnt, o_m0_rvalid, o_m0_err, o_m0_rddata,
      input  i_m1_req, i_m1_wen, i_m1_lock, i_m1_addr, i_m1_wrdata,
      output o_m1_gnt, o_m1_rvalid, o_m1_err, o_m1_rddata,
      output o_s_wen, o_s_ren, o_s_addr, o_s_wrdata,
      input  i_s_rddata
   );

   modport master (
      output i_m0_req, i_m0_wen, i_m0_lock, i_m0_addr, i_m0_wrdata,
      input  o_m0_gnt, o_m0_rvalid, o_m0_err, o_m0_rddata,
      output i_m1_req, i_m1_wen, i_m1_lock, i_m1_addr, i_m1_wrdata,
      input  o_m1_gnt, o_m1_rvalid, o_m1_err, o_m1_rddata,
      input  o_s_wen, o_s_ren, o_s_addr, o_s_wrdata,
      output i_s_rddata
   );
endinterface

// File: rtl/periph_arbiter.sv
// Two-master round-robin arbiter in front of one peripheral window.
// Optional bus locking is enabled by defining PERIPH_ARB_LOCK_EN.
//
// state | meaning
// IDLE  | accept a request; grant is combinational from req
// XFER  | one-cycle slave strobe (in-window only), read data captured
// RESP  | one-cycle rvalid/rddata/err back to the granted master
module periph_arbiter #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] BASE_ADDR = 32'h2000_0000,
   parameter logic [XLEN-1:0] WIN_SIZE  = 32'h0001_0000
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   periph_arbiter_if.slave      bus
);
   localparam logic [XLEN-1:0] LAST_ADDR = BASE_ADDR + WIN_SIZE - XLEN'(1);

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

   state_t          state_q, state_d;
   logic            rr_ptr_q;
   logic            lat_id_q, lat_wen_q, lat_inwin_q;
   logic [XLEN-1:0] lat_addr_q, lat_wrdata_q, rd_cap_q;

   logic            elig0, elig1, gnt0, gnt1, any_gnt, sel_id, sel_wen, sel_inwin;
   logic [XLEN-1:0] sel_addr, sel_wrdata;
   logic            s_ren, s_wen, s_strobe, rvalid;

   assign any_gnt    = gnt0 | gnt1;
   assign sel_id     = gnt1;
   assign sel_wen    = gnt1 ? bus.i_m1_wen    : bus.i_m0_wen;
   assign sel_addr   = gnt1 ? bus.i_m1_addr   : bus.i_m0_addr;
   assign sel_wrdata = gnt1 ? bus.i_m1_wrdata : bus.i_m0_wrdata;
   assign sel_inwin  = (sel_addr >= BASE_ADDR) && (sel_addr <= LAST_ADDR);

`ifdef PERIPH_ARB_LOCK_EN
   logic lock_vld_q, lock_id_q, sel_lock;

   assign sel_lock = gnt1 ? bus.i_m1_lock : bus.i_m0_lock;
   assign elig0    = bus.i_m0_req && (!lock_vld_q || !lock_id_q);
   assign elig1    = bus.i_m1_req && (!lock_vld_q ||  lock_id_q);

   // Only the owner can be granted while locked, so any unlocked grant releases.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         lock_vld_q <= 1'b0;
         lock_id_q  <= 1'b0;
      end else if (any_gnt) begin
         if (sel_lock) begin
            lock_vld_q <= 1'b1;
            lock_id_q  <= sel_id;
         end else if (lock_vld_q) begin
            lock_vld_q <= 1'b0;
         end
      end
   end
`else
   logic unused_lock;

   assign unused_lock = bus.i_m0_lock ^ bus.i_m1_lock;
   assign elig0       = bus.i_m0_req;
   assign elig1       = bus.i_m1_req;
`endif

   always_comb begin
      state_d = state_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      s_ren   = 1'b0;
      s_wen   = 1'b0;
      rvalid  = 1'b0;
      case (state_q)
         IDLE: begin
            // Grant is gated by reset so every output is quiet while held in reset.
            if (i_rst) begin
               if (elig0 && elig1) begin
                  gnt0 = !rr_ptr_q;
                  gnt1 =  rr_ptr_q;
               end else begin
                  gnt0 = elig0;
                  gnt1 = elig1;
               end
            end
            if (gnt0 || gnt1) state_d = XFER;
         end
         XFER: begin
            s_ren   = lat_inwin_q & ~lat_wen_q;
            s_wen   = lat_inwin_q &  lat_wen_q;
            state_d = RESP;
         end
         RESP: begin
            rvalid  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= 1'b0;
         lat_id_q     <= 1'b0;
         lat_wen_q    <= 1'b0;
         lat_inwin_q  <= 1'b0;
         lat_addr_q   <= '0;
         lat_wrdata_q <= '0;
         rd_cap_q     <= '0;
      end else begin
         state_q <= state_d;
         if (any_gnt) begin
            rr_ptr_q     <= ~sel_id;
            lat_id_q     <= sel_id;
            lat_wen_q    <= sel_wen;
            lat_inwin_q  <= sel_inwin;
            lat_addr_q   <= sel_addr;
            lat_wrdata_q <= sel_wrdata;
         end
         if (state_q == XFER) rd_cap_q <= s_ren ? bus.i_s_rddata : '0;
      end
   end

   assign s_strobe = s_ren | s_wen;

   assign bus.o_m0_gnt    = gnt0;
   assign bus.o_m1_gnt    = gnt1;
   assign bus.o_m0_rvalid = rvalid & ~lat_id_q;
   assign bus.o_m1_rvalid = rvalid &  lat_id_q;
   assign bus.o_m0_err    = rvalid & ~lat_id_q & ~lat_inwin_q;
   assign bus.o_m1_err    = rvalid &  lat_id_q & ~lat_inwin_q;
   assign bus.o_m0_rddata = (rvalid & ~lat_id_q) ? rd_cap_q : '0;
   assign bus.o_m1_rddata = (rvalid &  lat_id_q) ? rd_cap_q : '0;

   assign bus.o_s_ren    = s_ren;
   assign bus.o_s_wen    = s_wen;
   assign bus.o_s_addr   = s_strobe ? lat_addr_q   : '0;
   assign bus.o_s_wrdata = s_strobe ? lat_wrdata_q : '0;
endmodule

// File: tb/tb_periph_arbiter.sv
// Directed bench for periph_arbiter: vector table of single transactions plus
// hand-written sequences for round-robin, dropped requests, reset abort and locking.
module tb_periph_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] slv_data;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   periph_arbiter_if #(.XLEN(32)) bus ();

   periph_arbiter dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus)
   );

   // Slave model: read data is combinational from the read strobe.
   always_comb bus.i_s_rddata = bus.o_s_ren ? slv_data : 32'h0;

   typedef struct {
      logic        mid;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wrdata;
      logic [31:0] slv;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs[9];

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.i_m0_req = 1'b0; bus.i_m0_wen = 1'b0; bus.i_m0_lock = 1'b0;
      bus.i_m0_addr = 32'h0; bus.i_m0_wrdata = 32'h0;
      bus.i_m1_req = 1'b0; bus.i_m1_wen = 1'b0; bus.i_m1_lock = 1'b0;
      bus.i_m1_addr = 32'h0; bus.i_m1_wrdata = 32'h0;
   endtask

   task automatic set_m(input logic mid, input logic req, input logic wen, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wrdata);
      if (mid) begin
         bus.i_m1_req = req; bus.i_m1_wen = wen; bus.i_m1_lock = lock;
         bus.i_m1_addr = addr; bus.i_m1_wrdata = wrdata;
      end else begin
         bus.i_m0_req = req; bus.i_m0_wen = wen; bus.i_m0_lock = lock;
         bus.i_m0_addr = addr; bus.i_m0_wrdata = wrdata;
      end
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      logic inwin;
      v = vecs[i];
      inwin = !v.exp_err;
      @(negedge clk);
      drive_idle();
      set_m(v.mid, 1'b1, v.wen, 1'b0, v.addr, v.wrdata);
      slv_data = v.slv;
      #1;
      chk1($sformatf("v%0d gnt own", i), v.mid ? bus.o_m1_gnt : bus.o_m0_gnt, 1'b1);
      chk1($sformatf("v%0d gnt other", i), v.mid ? bus.o_m0_gnt : bus.o_m1_gnt, 1'b0);
      // Requester scribbles on its inputs after the grant; the latched copy must be used.
      @(negedge clk);
      drive_idle();
      set_m(v.mid, 1'b0, ~v.wen, 1'b0, 32'hFFFF_FFF0, 32'h5A5A_5A5A);
      #1;
      chk1($sformatf("v%0d s_ren", i), bus.o_s_ren, inwin & ~v.wen);
      chk1($sformatf("v%0d s_wen", i), bus.o_s_wen, inwin & v.wen);
      chk32($sformatf("v%0d s_addr", i), bus.o_s_addr, inwin ? v.addr : 32'h0);
      chk32($sformatf("v%0d s_wrdata", i), bus.o_s_wrdata, inwin ? v.wrdata : 32'h0);
      chk1($sformatf("v%0d early rvalid", i), bus.o_m0_rvalid | bus.o_m1_rvalid, 1'b0);
      @(negedge clk);
      drive_idle();
      #1;
      chk1($sformatf("v%0d rvalid own", i), v.mid ? bus.o_m1_rvalid : bus.o_m0_rvalid, 1'b1);
      chk1($sformatf("v%0d rvalid other", i), v.mid ? bus.o_m0_rvalid : bus.o_m1_rvalid, 1'b0);
      chk32($sformatf("v%0d rddata", i), v.mid ? bus.o_m1_rddata : bus.o_m0_rddata, v.exp_rd);
      chk32($sformatf("v%0d rddata other", i), v.mid ? bus.o_m0_rddata : bus.o_m1_rddata, 32'h0);
      chk1($sformatf("v%0d err", i), v.mid ? bus.o_m1_err : bus.o_m0_err, v.exp_err);
      chk1($sformatf("v%0d strobe in resp", i), bus.o_s_ren | bus.o_s_wen, 1'b0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      drive_idle();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ng;
      int last;
      logic exp_id;

      //        mid   wen   addr          wrdata        slave data    exp rddata    err
      vecs[0] = '{1'b0, 1'b0, 32'h2000_4000, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 32'h2000_4004, 32'h0000_0010, 32'h5555_5555, 32'h0,        1'b0};
      vecs[2] = '{1'b0, 1'b0, 32'h1000_0000, 32'h0,        32'h1111_1111, 32'h0,        1'b1};
      vecs[3] = '{1'b1, 1'b0, 32'h2000_0000, 32'h0,        32'h1234_5678, 32'h1234_5678, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 32'h2000_FFFF, 32'h0,        32'hA5A5_0001, 32'hA5A5_0001, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 32'h2001_0000, 32'h0,        32'h7777_7777, 32'h0,        1'b1};
      vecs[6] = '{1'b0, 1'b1, 32'h1FFF_FFFF, 32'h0000_00AB, 32'h0,        32'h0,        1'b1};
      vecs[7] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_CAFE, 32'h0,        32'h0,        1'b1};
      vecs[8] = '{1'b0, 1'b1, 32'h2000_FFFC, 32'h0000_1234, 32'h0,        32'h0,        1'b0};

      // Reset state with both masters requesting: every output quiet.
      slv_data = 32'h0;
      drive_idle();
      rst_n = 1'b0;
      set_m(1'b0, 1'b1, 1'b0, 1'b0, 32'h2000_0000, 32'h0);
      set_m(1'b1, 1'b1, 1'b1, 1'b0, 32'h2000_0004, 32'h1);
      #12;
      chk1("rst gnt0", bus.o_m0_gnt, 1'b0);
      chk1("rst gnt1", bus.o_m1_gnt, 1'b0);
      chk1("rst strobes", bus.o_s_ren | bus.o_s_wen, 1'b0);
      chk1("rst rvalid", bus.o_m0_rvalid | bus.o_m1_rvalid, 1'b0);
      chk32("rst s_addr", bus.o_s_addr, 32'h0);
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(i);

      // Both masters requesting continuously from reset: m0, m1, m0, m1, 3 cycles apart.
      pulse_reset();
      set_m(1'b0, 1'b1, 1'b0, 1'b0, 32'h2000_0100, 32'h0);
      set_m(1'b1, 1'b1, 1'b0, 1'b0, 32'h2000_0200, 32'h0);
      ng = 0;
      last = -1;
      exp_id = 1'b0;
      for (int cyc = 0; cyc < 30 && ng < 4; cyc++) begin
         if (cyc > 0) @(negedge clk);
         #1;
         if (bus.o_m0_gnt || bus.o_m1_gnt) begin
            chk1($sformatf("rr grant %0d id", ng), bus.o_m1_gnt, exp_id);
            chk1($sformatf("rr grant %0d onehot", ng), bus.o_m0_gnt & bus.o_m1_gnt, 1'b0);
            chk32($sformatf("rr grant %0d cycle", ng), 32'(cyc), 32'(ng * 3));
            last = cyc;
            exp_id = ~exp_id;
            ng++;
         end
      end
      chk32("rr grants seen", 32'(ng), 32'd4);
      chk32("rr last grant cycle", 32'(last), 32'd9);
      drive_idle();
      repeat (3) @(negedge clk);

      // Request raised only while busy, then dropped: no grant, no side effect.
      @(negedge clk);
      set_m(1'b0, 1'b1, 1'b0, 1'b0, 32'h2000_0010, 32'h0);
      @(negedge clk);
      drive_idle();
      set_m(1'b1, 1'b1, 1'b1, 1'b0, 32'h2000_0008, 32'h99);
      #1;
      chk1("busy no gnt1", bus.o_m1_gnt, 1'b0);
      @(negedge clk);
      drive_idle();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk1($sformatf("dropped gnt c%0d", k), bus.o_m0_gnt | bus.o_m1_gnt, 1'b0);
         chk1($sformatf("dropped wen c%0d", k), bus.o_s_wen, 1'b0);
      end

      // Reset asserted in XFER aborts the transfer.
      @(negedge clk);
      slv_data = 32'h0000_BEEF;
      set_m(1'b0, 1'b1, 1'b0, 1'b0, 32'h2000_4000, 32'h0);
      @(negedge clk);
      #1;
      chk1("abort pre ren", bus.o_s_ren, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("abort ren", bus.o_s_ren, 1'b0);
      chk32("abort s_addr", bus.o_s_addr, 32'h0);
      chk1("abort gnt", bus.o_m0_gnt, 1'b0);
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk1($sformatf("abort stale rvalid c%0d", k), bus.o_m0_rvalid | bus.o_m1_rvalid, 1'b0);
      end
      run_vec(0);

`ifdef PERIPH_ARB_LOCK_EN
      // m0 locks, then its unlocked follow-up wins over a waiting m1.
      pulse_reset();
      set_m(1'b0, 1'b1, 1'b0, 1'b1, 32'h2000_BFF8, 32'h0);
      set_m(1'b1, 1'b1, 1'b0, 1'b0, 32'h2000_0300, 32'h0);
      #1;
      chk1("lock first gnt0", bus.o_m0_gnt, 1'b1);
      chk1("lock first gnt1", bus.o_m1_gnt, 1'b0);
      @(negedge clk);
      set_m(1'b0, 1'b1, 1'b0, 1'b0, 32'h2000_BFFC, 32'h0);
      repeat (2) @(negedge clk);
      #1;
      chk1("lock second gnt0", bus.o_m0_gnt, 1'b1);
      chk1("lock second gnt1", bus.o_m1_gnt, 1'b0);
      @(negedge clk);
      set_m(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      #1;
      chk1("lock third gnt1", bus.o_m1_gnt, 1'b1);
      drive_idle();
      repeat (3) @(negedge clk);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/periph_arbiter.md
PERIPH_ARBITER -- requirements
Module: periph_arbiter

Interface
REQ-001 Parameter BASE_ADDR, 32'h2000_0000, base of the decoded peripheral window (the timer/interrupt block address space).
REQ-002 Parameter WIN_SIZE, 32'h0001_0000, window size in bytes; the window is [BASE_ADDR, BASE_ADDR+WIN_SIZE).
REQ-003 i_clk  in  1  sole clock; all state on rising edge.
REQ-004 i_rst  in  1  asynchronous, active-low reset.
REQ-005 i_mN_req / i_mN_wen / i_mN_lock  in  1 each (N=0,1)  request, write-not-read, lock.
REQ-006 i_mN_addr / i_mN_wrdata  in  XLEN each  request address and write data.
REQ-007 o_mN_gnt  out  1  request accepted this cycle.
REQ-008 o_mN_rvalid / o_mN_err  out  1 each  response strobe, out-of-window error.
REQ-009 o_mN_rddata  out  XLEN  response read data.
REQ-010 o_s_wen / o_s_ren  out  1 each  one-cycle slave strobes.
REQ-011 o_s_addr / o_s_wrdata  out  XLEN each  slave address and write data.
REQ-012 i_s_rddata  in  XLEN  slave read data, combinational from o_s_addr/o_s_ren.

Function
REQ-013 FSM states: IDLE, XFER, RESP; IDLE->XFER on any grant, XFER->RESP unconditionally, RESP->IDLE unconditionally.
REQ-014 In IDLE, grant is combinational: at most one o_mN_gnt high, asserted in the same cycle as the winning i_mN_req; no gnt outside IDLE.
REQ-015 On grant, master id, addr, wrdata, wen, lock and in-window flag are latched; requester may change inputs from the next cycle.
REQ-016 Arbitration is round-robin: with both requesting, the master not granted most recently wins; a single requester always wins; pointer favours m0 after reset.
REQ-017 In XFER, for an in-window request, exactly one of o_s_wen/o_s_ren is high for one cycle with latched addr/wrdata; i_s_rddata is registered at the end of XFER.
REQ-018 In XFER, for an out-of-window request, no slave strobe is issued.
REQ-019 In RESP, the granted master sees o_mN_rvalid=1 for one cycle; o_mN_rddata = captured data for in-window reads, 0 for writes and out-of-window; o_mN_err=1 only for out-of-window.
REQ-020 Latency: req in cycle T -> gnt T, slave strobe T+1, rvalid T+2; earliest next gnt T+3.
REQ-021 o_s_addr/o_s_wrdata are 0 whenever no slave strobe is high; o_mN_rddata is 0 whenever o_mN_rvalid is low.
REQ-022 Window check uses unsigned XLEN arithmetic; BASE_ADDR+WIN_SIZE-1 is the last in-window byte; addresses must not wrap.
REQ-023 A request deasserted before grant is dropped without side effects.

Reset
REQ-024 On i_rst=0, asynchronously: state=IDLE, pointer=m0, lock cleared, latched registers 0; all outputs 0.
REQ-025 Reset during XFER or RESP aborts the transaction: no rvalid is issued, and a strobe in progress is deasserted immediately.

Configuration
REQ-026 Macro PERIPH_ARB_LOCK_EN: when defined, a grant with i_mN_lock=1 sets lock-owner=N; while owned, IDLE grants only master N; the owner's next grant with lock=0 clears ownership. Out-of-window locked requests still set ownership.
REQ-027 Without PERIPH_ARB_LOCK_EN, the i_mN_lock ports remain present and are ignored; arbitration is pure round-robin.

Verification
REQ-028 m0 read at BASE_ADDR+32'h4000, slave returns 32'hDEAD_BEEF -> gnt0 at T, o_s_ren at T+1, rvalid0 at T+2 with rddata 32'hDEAD_BEEF and err0=0.
REQ-029 m0 and m1 both request continuously from reset -> grant order m0, m1, m0, m1, each grant 3 cycles apart.
REQ-030 m1 write 32'h0000_0010 to BASE_ADDR+32'h4004 -> o_s_wen for one cycle with that addr/data; rvalid1 with rddata 0.
REQ-031 m0 read at 32'h1000_0000 -> no slave strobe; rvalid0 with err0=1, rddata 0.
REQ-032 With PERIPH_ARB_LOCK_EN: m0 locked read of BASE_ADDR+32'hBFF8, m1 requesting -> m0's unlocked read of BASE_ADDR+32'hBFFC is granted before m1; m1 is granted next.
REQ-033 i_rst asserted in XFER -> strobes and outputs 0 immediately; after release, the first request is granted normally with no stale rvalid.
